hwpe_ctrl2obi: RTL and testbench

Bridge from an HWPE-ctrl target port to an OBI manager port. An HWPE-ctrl master (a cluster controller or a remote tile's peripheral path) uses it to program OBI-attached tile peripherals and register files. The request side is combinational. Outstanding transactions are tracked in an ID FIFO, because OBI in this configuration carries no ID. Responses are returned registered, in order, with the original HWPE-ctrl ID restored.

---
 rtl/hwpe_ctrl2obi_pkg.sv | 63 ++++++
 rtl/hwpe_ctrl2obi_if.sv | 66 ++++++
 rtl/hwpe_ctrl2obi_id_fifo.sv | 83 ++++++++
 rtl/hwpe_ctrl2obi.sv | 127 ++++++++++++
 tb/tb_hwpe_ctrl2obi.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_ctrl2obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl2obi_pkg
// Description : Shared types and constants for the HWPE-ctrl to OBI bridge.
//               Holds the default bus widths and request/response structs for
//               both ports, the default ID-FIFO depth and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_ctrl2obi_pkg;

    localparam int c_addr_w                  = 32;
    localparam int c_data_w                  = 32;
    localparam int c_id_w                    = 8;
    localparam int c_default_max_outstanding = 2;

    // HWPE-ctrl target port, request direction (master -> bridge)
    typedef struct packed {
        logic                  req;
        logic [c_addr_w-1:0]   add;
        logic                  wen;
        logic [c_data_w/8-1:0] be;
        logic [c_data_w-1:0]   data;
        logic [c_id_w-1:0]     id;
    } hwpe_ctrl_req_t;

    // HWPE-ctrl target port, response direction (bridge -> master)
    typedef struct packed {
        logic                gnt;
        logic                r_valid;
        logic [c_data_w-1:0] r_data;
        logic [c_id_w-1:0]   r_id;
    } hwpe_ctrl_rsp_t;

    // OBI manager port, request direction (bridge -> subordinate)
    typedef struct packed {
        logic                  req;
        logic [c_addr_w-1:0]   addr;
        logic                  we;
        logic [c_data_w/8-1:0] be;
        logic [c_data_w-1:0]   wdata;
        logic                  rready;
    } core_obi_data_req_t;

    // OBI manager port, response direction (subordinate -> bridge)
    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [c_data_w-1:0] rdata;
        logic                err;
    } core_obi_data_rsp_t;

    // Width of a counter that must hold values 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer addressing depth entries; never below one bit
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl2obi_if.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl2obi_ctrl_if / hwpe_ctrl2obi_obi_if
// Description : Bus interfaces for the bridge. The ctrl interface carries the
//               HWPE-ctrl request/response; the obi interface carries the OBI
//               address and response phases. Modport "master" is the side
//               that issues requests, "slave" the side that answers them.
// Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_ctrl2obi_ctrl_if
    import hwpe_ctrl2obi_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w,
    parameter int ID_W   = c_id_w
);
    logic                  req;
    logic [ADDR_W-1:0]     add;
    logic                  wen;      // 1 = read, 0 = write
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     data;
    logic [ID_W-1:0]       id;
    logic                  gnt;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [ID_W-1:0]       r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data, r_id
    );
endinterface

interface hwpe_ctrl2obi_obi_if
    import hwpe_ctrl2obi_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;       // 1 = write
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/hwpe_ctrl2obi_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl2obi_id_fifo
// Description : Synchronous FIFO holding the IDs of granted transactions.
//               Fall-through head read, any depth >= 1 (pointers wrap at
//               DEPTH, not at a power of two). Push is ignored when full and
//               pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl2obi_id_fifo
    import hwpe_ctrl2obi_pkg::*;
#(
    parameter int WIDTH = c_id_w,
    parameter int DEPTH = c_default_max_outstanding
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        push,
    input  wire logic [WIDTH-1:0]            wdata,
    input  wire logic                        pop,
    output logic      [WIDTH-1:0]            rdata,
    output logic                             full,
    output logic                             empty,
    output logic      [cnt_width(DEPTH)-1:0] count
);

    localparam int                  c_ptr_w = ptr_width(DEPTH);
    localparam int                  c_cnt_w = cnt_width(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_last  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage array; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl2obi.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl2obi
// Description : HWPE-ctrl target to OBI manager bridge. Requests pass through
//               combinationally, throttled by the number of outstanding
//               transactions. OBI carries no ID here, so granted IDs are kept
//               in order in a FIFO and reattached to the registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl2obi
    import hwpe_ctrl2obi_pkg::*;
#(
    parameter int ADDR_W          = c_addr_w,
    parameter int DATA_W          = c_data_w,
    parameter int ID_W            = c_id_w,
    parameter int MAX_OUTSTANDING = c_default_max_outstanding
) (
    input  wire logic                                  clk_i,
    input  wire logic                                  rst_i,
    hwpe_ctrl2obi_ctrl_if.slave                        ctrl,
    hwpe_ctrl2obi_obi_if.master                        obi,
    output logic      [cnt_width(MAX_OUTSTANDING)-1:0] outstanding_o,
    output logic                                       err_o,
    output logic                                       unexpected_rsp_o
);

    localparam int c_cnt_w = cnt_width(MAX_OUTSTANDING);

    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_be;
    logic                w_full;
    logic                w_empty;
    logic                w_obi_req;
    logic                w_push;
    logic                w_pop;
    logic                w_unexpected;
    logic [ID_W-1:0]     w_head_id;
    logic [c_cnt_w-1:0]  w_count;

    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_err;
    logic                r_unexpected;

    // ------------------------------------------------------------------
    // Address phase. Throttling looks only at the registered occupancy, so
    // a response arriving this cycle cannot open the gate in the same cycle
    // and there is no rvalid -> gnt path.
    // ------------------------------------------------------------------
    assign w_addr    = ctrl.add;
    assign w_wdata   = ctrl.data;
    assign w_be      = ctrl.be;

    assign w_obi_req = ctrl.req & ~w_full;
    assign w_push    = obi.gnt & w_obi_req;

    assign obi.req    = w_obi_req;
    assign obi.addr   = w_addr;
    assign obi.wdata  = w_wdata;
    assign obi.be     = w_be;
    assign obi.we     = ~ctrl.wen;
    assign obi.rready = 1'b1;
    assign ctrl.gnt   = w_push;

    // ------------------------------------------------------------------
    // Response phase. The pop decision uses pre-push emptiness, so an
    // rvalid that lands together with the first grant is still stray.
    // ------------------------------------------------------------------
    assign w_pop        = obi.rvalid & ~w_empty;
    assign w_unexpected = obi.rvalid & w_empty;

    hwpe_ctrl2obi_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (w_push),
        .wdata (ctrl.id),
        .pop   (w_pop),
        .rdata (w_head_id),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Registered response: one-cycle valid pulse, data/ID hold between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_data <= obi.rdata;
                r_rsp_id   <= w_head_id;
            end
        end
    end

    // Sticky status flags, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err        <= 1'b0;
            r_unexpected <= 1'b0;
        end else begin
            if (obi.rvalid & obi.err) begin
                r_err <= 1'b1;
            end
            if (w_unexpected) begin
                r_unexpected <= 1'b1;
            end
        end
    end

    assign ctrl.r_valid     = r_rsp_valid;
    assign ctrl.r_data      = r_rsp_data;
    assign ctrl.r_id        = r_rsp_id;
    assign outstanding_o    = w_count;
    assign err_o            = r_err;
    assign unexpected_rsp_o = r_unexpected;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl2obi.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_ctrl2obi
// Description : Directed bench for hwpe_ctrl2obi. Expected responses are
//               queued when the OBI response is driven; a negedge monitor
//               pops and compares ID, data and arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl2obi;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 8;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hwpe_ctrl2obi_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) ctrl_bus ();
    hwpe_ctrl2obi_obi_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))              obi_bus ();

    logic [CNT_W-1:0] outstanding;
    logic             err;
    logic             unexp;

    hwpe_ctrl2obi #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .ID_W            (ID_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ctrl             (ctrl_bus),
        .obi              (obi_bus),
        .outstanding_o    (outstanding),
        .err_o            (err),
        .unexpected_rsp_o (unexp)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (ctrl_bus.r_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_r_valid", 64'(ctrl_bus.r_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("r_id", 64'(ctrl_bus.r_id), 64'(e.id));
                check("r_data", 64'(ctrl_bus.r_data), 64'(e.data));
                check("r_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        ctrl_bus.req   = 1'b0;
        obi_bus.gnt    = 1'b0;
        obi_bus.rvalid = 1'b0;
        obi_bus.err    = 1'b0;
    endtask

    task automatic request(input logic [ID_W-1:0] id, input logic wen,
                           input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                           input logic [DATA_W-1:0] data, input logic grant);
        ctrl_bus.req  = 1'b1;
        ctrl_bus.id   = id;
        ctrl_bus.wen  = wen;
        ctrl_bus.add  = addr;
        ctrl_bus.be   = be;
        ctrl_bus.data = data;
        obi_bus.gnt   = grant;
    endtask

    // Drive an OBI response this cycle; queue the expected ctrl response
    task automatic respond(input logic [DATA_W-1:0] rdata, input logic e,
                           input logic expect_it, input logic [ID_W-1:0] id);
        obi_bus.rvalid = 1'b1;
        obi_bus.rdata  = rdata;
        obi_bus.err    = e;
        if (expect_it) exp_q.push_back('{id, rdata, cyc + 1});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_r_valid"}, 64'(ctrl_bus.r_valid), 64'd0);
        check({tag, "_r_data"}, 64'(ctrl_bus.r_data), 64'd0);
        check({tag, "_r_id"}, 64'(ctrl_bus.r_id), 64'd0);
        check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_unexp"}, 64'(unexp), 64'd0);
        check({tag, "_rready"}, 64'(obi_bus.rready), 64'd1);
    endtask

    initial begin
        idle();
        ctrl_bus.id    = '0;
        ctrl_bus.wen   = 1'b1;
        ctrl_bus.add   = '0;
        ctrl_bus.be    = '0;
        ctrl_bus.data  = '0;
        obi_bus.rdata  = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sample();
        check_reset_state("reset");

        // Single read, granted immediately, response two cycles later
        step(); request(8'h5A, 1'b1, 32'h100, 4'hF, 32'h0, 1'b1);
        sample();
        check("rd_gnt", 64'(ctrl_bus.gnt), 64'd1);
        check("rd_obi_req", 64'(obi_bus.req), 64'd1);
        check("rd_we", 64'(obi_bus.we), 64'd0);
        check("rd_addr", 64'(obi_bus.addr), 64'h100);
        step(); idle();
        sample();
        check("rd_outstanding", 64'(outstanding), 64'd1);
        step(); respond(32'hDEADBEEF, 1'b0, 1'b1, 8'h5A);
        step(); idle();
        sample();
        check("rd_outstanding_after", 64'(outstanding), 64'd0);

        // Write with partial byte enables
        step(); request(8'h77, 1'b0, 32'h204, 4'h3, 32'h1234, 1'b1);
        sample();
        check("wr_we", 64'(obi_bus.we), 64'd1);
        check("wr_be", 64'(obi_bus.be), 64'h3);
        check("wr_wdata", 64'(obi_bus.wdata), 64'h1234);
        check("wr_gnt", 64'(ctrl_bus.gnt), 64'd1);
        step(); idle();
        step(); respond(32'hCAFE0001, 1'b0, 1'b1, 8'h77);
        step(); idle();

        // Back-pressure at MAX_OUTSTANDING
        step(); request(8'h01, 1'b1, 32'h300, 4'hF, 32'h0, 1'b1);
        sample();
        check("bp_gnt1", 64'(ctrl_bus.gnt), 64'd1);
        step(); request(8'h02, 1'b1, 32'h304, 4'hF, 32'h0, 1'b1);
        sample();
        check("bp_gnt2", 64'(ctrl_bus.gnt), 64'd1);
        step(); request(8'h03, 1'b1, 32'h308, 4'hF, 32'h0, 1'b1);
        sample();
        check("bp_full_obi_req", 64'(obi_bus.req), 64'd0);
        check("bp_full_gnt", 64'(ctrl_bus.gnt), 64'd0);
        check("bp_full_outstanding", 64'(outstanding), 64'd2);
        step(); respond(32'h11, 1'b0, 1'b1, 8'h01);
        sample();
        check("bp_pop_same_cycle_gnt", 64'(ctrl_bus.gnt), 64'd0);
        step(); obi_bus.rvalid = 1'b0;
        sample();
        check("bp_gnt3", 64'(ctrl_bus.gnt), 64'd1);
        check("bp_outstanding_1", 64'(outstanding), 64'd1);
        step(); idle(); respond(32'h22, 1'b0, 1'b1, 8'h02);
        sample();
        check("bp_outstanding_2", 64'(outstanding), 64'd2);
        step(); respond(32'h33, 1'b0, 1'b1, 8'h03);
        step(); idle();
        sample();
        check("bp_drained", 64'(outstanding), 64'd0);

        // Same-cycle grant and response with one outstanding
        step(); request(8'h40, 1'b1, 32'h400, 4'hF, 32'h0, 1'b1);
        step(); request(8'h41, 1'b1, 32'h404, 4'hF, 32'h0, 1'b1);
        respond(32'h44, 1'b0, 1'b1, 8'h40);
        sample();
        check("sim_gnt", 64'(ctrl_bus.gnt), 64'd1);
        step(); idle();
        sample();
        check("sim_outstanding", 64'(outstanding), 64'd1);
        step(); respond(32'h55, 1'b0, 1'b1, 8'h41);
        step(); idle();

        // Error response is forwarded and sets the sticky flag
        step(); request(8'h60, 1'b1, 32'h500, 4'hF, 32'h0, 1'b1);
        step(); idle();
        sample();
        check("err_before", 64'(err), 64'd0);
        step(); respond(32'h66, 1'b1, 1'b1, 8'h60);
        step(); idle();
        sample();
        check("err_set", 64'(err), 64'd1);
        step(); step();
        sample();
        check("err_sticky", 64'(err), 64'd1);

        // Stray response with nothing outstanding is dropped
        step(); respond(32'h99, 1'b0, 1'b0, 8'h00);
        step(); idle();
        sample();
        check("unexp_set", 64'(unexp), 64'd1);
        check("unexp_outstanding", 64'(outstanding), 64'd0);

        // Reset with two transactions in flight
        step(); request(8'h80, 1'b1, 32'h600, 4'hF, 32'h0, 1'b1);
        step(); request(8'h81, 1'b1, 32'h604, 4'hF, 32'h0, 1'b1);
        step(); idle(); rst = 1'b1;
        sample();
        check("pre_rst_outstanding", 64'(outstanding), 64'd2);
        step(); rst = 1'b0;
        sample();
        check_reset_state("midrst");

        // Stale response lands together with the first new grant
        step(); request(8'h90, 1'b1, 32'h700, 4'hF, 32'h0, 1'b1);
        respond(32'hBAD0BAD0, 1'b0, 1'b0, 8'h00);
        sample();
        check("post_rst_gnt", 64'(ctrl_bus.gnt), 64'd1);
        step(); idle();
        sample();
        check("post_rst_unexp", 64'(unexp), 64'd1);
        check("post_rst_outstanding", 64'(outstanding), 64'd1);
        step(); respond(32'hA5A5A5A5, 1'b0, 1'b1, 8'h90);
        step(); idle();
        step(); step(); step();
        sample();
        check("pending_rsp", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
